// File: rtl/wallace_mac_pipe.sv
// Pipelined Wallace-tree multiply-accumulate unit with per-beat signed/unsigned mode,
// valid/ready handshake with global stall, and an accumulator with sticky overflow.
module wallace_mac_pipe #(
  parameter int WIDTH     = 16,
  parameter int STAGES    = 4,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_en,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 acc_ovf
);

  localparam int PW   = 2*WIDTH;
  localparam int GMAX = (WIDTH+1)/3;

  typedef struct packed {
    logic          valid;
    logic          sgn;
    logic          acc_en;
    logic          acc_clr;
    logic [PW-1:0] x;
    logic [PW-1:0] y;
  } beat_t;

  // Stage roles: 0 pass, 1 compressor tree, 2 final adder, 3 tree and adder together.
  function automatic int stage_mode(input int j);
    if (STAGES == 1) begin
      return 3;
    end else if (STAGES == 2) begin
      return j;
    end else if (j == 2) begin
      return 1;
    end else if (j == 3) begin
      return 2;
    end else begin
      return 0;
    end
  endfunction

  // Baugh-Wooley partial products reduced row-wise by 3:2 compressors to a sum/carry pair.
  function automatic logic [2*PW-1:0] csa_tree(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             sgn);
    logic [PW-1:0] rows [0:WIDTH];
    logic [PW-1:0] nxt  [0:WIDTH];
    logic          pp;
    int            n;
    int            m;
    int            g;
    for (int i = 0; i < WIDTH; i++) begin
      rows[i] = '0;
      for (int j = 0; j < WIDTH; j++) begin
        pp = x[i] & y[j];
        if (sgn && ((i == WIDTH-1) != (j == WIDTH-1))) begin
          pp = ~pp;
        end else begin
          pp = pp;
        end
        rows[i][i+j] = pp;
      end
    end
    rows[WIDTH] = '0;
    if (sgn) begin
      rows[WIDTH][WIDTH] = 1'b1;
      rows[WIDTH][PW-1]  = 1'b1;
    end else begin
      rows[WIDTH] = '0;
    end
    n = WIDTH + 1;
    for (int lvl = 0; lvl < WIDTH; lvl++) begin
      if (n > 2) begin
        g = n / 3;
        m = 0;
        for (int k = 0; k <= WIDTH; k++) nxt[k] = '0;
        for (int k = 0; k < GMAX; k++) begin
          if (k < g) begin
            nxt[m]   = rows[3*k] ^ rows[3*k+1] ^ rows[3*k+2];
            nxt[m+1] = ((rows[3*k] & rows[3*k+1]) | (rows[3*k] & rows[3*k+2]) |
                        (rows[3*k+1] & rows[3*k+2])) << 1;
            m = m + 2;
          end
        end
        for (int k = 0; k <= WIDTH; k++) begin
          if (k >= 3*g && k < n) begin
            nxt[m] = rows[k];
            m = m + 1;
          end
        end
        rows = nxt;
        n    = m;
      end
    end
    return {rows[0], rows[1]};
  endfunction

  beat_t                in_beat;
  beat_t                stage_q [1:STAGES];
  beat_t                stage_d [1:STAGES];
  logic                 adv;
  logic                 xfer;
  logic [ACC_WIDTH-1:0] base_s;
  logic [ACC_WIDTH-1:0] ext_s;
  logic [ACC_WIDTH:0]   sum_s;
  logic                 ovf_s;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = stage_q[STAGES].valid;
  assign product   = stage_q[STAGES].x;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    in_beat.valid   = in_valid;
    in_beat.sgn     = signed_en;
    in_beat.acc_en  = acc_en;
    in_beat.acc_clr = acc_clr;
    in_beat.x       = {{(PW-WIDTH){1'b0}}, a};
    in_beat.y       = {{(PW-WIDTH){1'b0}}, b};
  end

  // Bubbles keep the previous stage data so a stalled or idle product output stays quiet.
  always_comb begin
    beat_t src;
    beat_t nb;
    for (int j = 1; j <= STAGES; j++) begin
      src = (j == 1) ? in_beat : stage_q[(j > 1) ? j-1 : 1];
      nb  = src;
      if (!src.valid) begin
        nb       = stage_q[j];
        nb.valid = 1'b0;
      end else begin
        case (stage_mode(j))
          1: {nb.x, nb.y} = csa_tree(src.x[WIDTH-1:0], src.y[WIDTH-1:0], src.sgn);
          2: begin
            nb.x = src.x + src.y;
            nb.y = '0;
          end
          3: begin
            {nb.x, nb.y} = csa_tree(src.x[WIDTH-1:0], src.y[WIDTH-1:0], src.sgn);
            nb.x = nb.x + nb.y;
            nb.y = '0;
          end
          default: nb = src;
        endcase
      end
      stage_d[j] = nb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 1; j <= STAGES; j++) stage_q[j] <= '0;
    end else if (adv) begin
      for (int j = 1; j <= STAGES; j++) stage_q[j] <= stage_d[j];
    end
  end

  always_comb begin
    base_s = stage_q[STAGES].acc_clr ? '0 : acc;
    ext_s  = stage_q[STAGES].sgn ? ACC_WIDTH'($signed(product)) : ACC_WIDTH'(product);
    sum_s  = {1'b0, base_s} + {1'b0, ext_s};
    if (stage_q[STAGES].sgn) begin
      ovf_s = (base_s[ACC_WIDTH-1] == ext_s[ACC_WIDTH-1]) &&
              (sum_s[ACC_WIDTH-1] != base_s[ACC_WIDTH-1]);
    end else begin
      ovf_s = sum_s[ACC_WIDTH];
    end
  end

  // A clearing beat restarts the sticky flag from its own overflow status.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (xfer && stage_q[STAGES].acc_en) begin
      acc     <= sum_s[ACC_WIDTH-1:0];
      acc_ovf <= stage_q[STAGES].acc_clr ? ovf_s : (acc_ovf | ovf_s);
    end
  end

endmodule

// File: tb/tb_wallace_mac_pipe.sv
// Self-checking bench: directed steps plus randomized beats scored against a queue-based
// arithmetic reference model of products and the accumulator.
module tb_wallace_mac_pipe;
  localparam int W   = 16;
  localparam int S   = 4;
  localparam int AW  = 2*W+8;
  localparam int AW2 = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           in_valid = 1'b0, signed_en = 1'b0, acc_en = 1'b0, acc_clr = 1'b0;
  logic           out_ready = 1'b1;
  logic [W-1:0]   a = '0, b = '0;
  logic           in_ready, out_valid, acc_ovf;
  logic [2*W-1:0] product;
  logic [AW-1:0]  acc;

  logic           in_valid2 = 1'b0, acc_clr2 = 1'b0;
  logic [W-1:0]   a2 = '0, b2 = '0;
  logic           in_ready2, out_valid2, acc_ovf2;
  logic [2*W-1:0] product2;
  logic [AW2-1:0] acc2;

  wallace_mac_pipe #(.WIDTH(W), .STAGES(S), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .signed_en(signed_en), .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .acc(acc), .acc_ovf(acc_ovf));

  wallace_mac_pipe #(.WIDTH(W), .STAGES(S), .ACC_WIDTH(AW2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .signed_en(1'b0), .acc_en(1'b1), .acc_clr(acc_clr2), .out_valid(out_valid2),
    .out_ready(1'b1), .product(product2), .acc(acc2), .acc_ovf(acc_ovf2));

  typedef struct {
    logic [31:0] p;
    bit          sgn;
    bit          en;
    bit          clr;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  int     n_vec = 0, n_err = 0, n_push = 0, n_pop = 0;
  longint acc_m = 0;
  bit     ovf_m = 1'b0;

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input bit s);
    longint r;
    if (s) r = longint'($signed(x)) * longint'($signed(y));
    else   r = longint'(x) * longint'(y);
    return r[31:0];
  endfunction

  task automatic acc_step(input int aw, input logic [31:0] p, input bit sgn, input bit clr,
                          inout longint accv, inout bit ovf);
    longint md, t, bs;
    bit     o;
    md = longint'(1) << aw;
    if (sgn) begin
      bs = clr ? 64'sd0 : ((accv >= md/2) ? accv - md : accv);
      t  = bs + longint'($signed(p));
      o  = (t >= md/2) || (t < -(md/2));
    end else begin
      t = (clr ? 64'sd0 : accv) + longint'(p);
      o = (t >= md);
    end
    accv = t & (md - 1);
    ovf  = clr ? o : (ovf | o);
  endtask

  // Scoreboard: every cycle check acc/acc_ovf, every presented product, then advance the model.
  always @(negedge clk) begin
    n_vec++;
    assert (acc === acc_m[AW-1:0] && acc_ovf === ovf_m)
      else begin n_err++; $error("FAIL acc: got %h/%b want %h/%b", acc, acc_ovf, acc_m[AW-1:0], ovf_m); end
    if (out_valid) begin
      n_vec++;
      assert (q.size() != 0)
        else begin n_err++; $error("FAIL spurious_out: got out_valid=1 product=%h want no beat", product); end
      if (q.size() != 0) begin
        n_vec++;
        assert (product === q[0].p)
          else begin n_err++; $error("FAIL product: got %h want %h", product, q[0].p); end
      end
    end
    if (rst) begin
      q.delete();
      acc_m = 0;
      ovf_m = 1'b0;
    end else begin
      if (out_valid && out_ready && q.size() != 0) begin
        mon_e = q.pop_front();
        n_pop++;
        if (mon_e.en) acc_step(AW, mon_e.p, mon_e.sgn, mon_e.clr, acc_m, ovf_m);
      end
      if (in_valid && in_ready) begin
        q.push_back('{p: ref_mul(a, b, signed_en), sgn: signed_en, en: acc_en, clr: acc_clr});
        n_push++;
      end
    end
  end

  task automatic run_one(input logic [15:0] x, input logic [15:0] y, input bit s,
                         input logic [31:0] want, input string tag);
    int lat;
    bit seen;
    in_valid = 1'b1; a = x; b = y; signed_en = s; acc_en = 1'b0; acc_clr = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    assert (seen && lat == S)
      else begin n_err++; $error("FAIL %s_latency: got %0d (seen=%0b) want %0d", tag, lat, seen, S); end
    n_vec++;
    assert (product === want)
      else begin n_err++; $error("FAIL %s_product: got %h want %h", tag, product, want); end
    @(negedge clk);
    n_vec++;
    assert (out_valid === 1'b0)
      else begin n_err++; $error("FAIL %s_hold: got out_valid=%b want 0", tag, out_valid); end
    @(posedge clk); #1;
  endtask

  logic [15:0] ta [10] = '{16'h0000, 16'h0001, 16'h0003, 16'h00FF, 16'h0F0F,
                           16'hAAAA, 16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF};
  logic [15:0] tb [10] = '{16'h0000, 16'h0001, 16'h0004, 16'h000F, 16'h00F0,
                           16'h5555, 16'h5678, 16'h0002, 16'h7FFF, 16'hFFFF};
  logic [15:0] ra [30], rb [30];
  bit          rs [30], re [30], rc [30];
  logic [15:0] ov;
  logic [31:0] held;
  int          idx, cnt;
  longint      acc2_m;
  bit          ovf2_m;

  initial begin
    // Step 1: reset, then reset state and the full-scale unsigned product.
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    assert (out_valid === 1'b0 && product === 32'h0 && acc === '0 && acc_ovf === 1'b0 && in_ready === 1'b1)
      else begin n_err++; $error("FAIL reset_state: got ov=%b p=%h acc=%h ovf=%b rdy=%b want 0/0/0/0/1",
                                 out_valid, product, acc, acc_ovf, in_ready); end
    @(posedge clk); #1;
    run_one(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u_ffff_sq");

    // Step 2: signed corner cases against the unsigned reading of the same bits.
    run_one(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_min_sq");
    run_one(16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, "s_m1x2");
    run_one(16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, "u_ffffx2");

    // Step 3: ten back-to-back beats; results must be ten consecutive cycles starting at cycle 4.
    ov = '0;
    for (int k = 0; k < 16; k++) begin
      in_valid = (k < 10);
      if (k < 10) begin a = ta[k]; b = tb[k]; signed_en = 1'b0; acc_en = 1'b0; acc_clr = 1'b0; end
      @(negedge clk);
      ov[k] = out_valid;
      @(posedge clk); #1;
    end
    n_vec++;
    assert (ov === 16'b0011_1111_1111_0000)
      else begin n_err++; $error("FAIL stream_timing: got %b want %b", ov, 16'b0011_1111_1111_0000); end

    // Step 4: randomized beats with random backpressure and a forced 5-cycle stall.
    for (int i = 0; i < 30; i++) begin
      ra[i] = 16'($urandom); rb[i] = 16'($urandom);
      rs[i] = 1'($urandom); re[i] = 1'($urandom); rc[i] = ($urandom_range(0, 3) == 0);
    end
    idx = 0; held = '0;
    for (int k = 0; k < 90; k++) begin
      in_valid = (idx < 30);
      if (idx < 30) begin
        a = ra[idx]; b = rb[idx]; signed_en = rs[idx]; acc_en = re[idx]; acc_clr = rc[idx];
      end
      if (k < 6)       out_ready = 1'b1;
      else if (k < 11) out_ready = 1'b0;
      else             out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (k == 6) held = product;
      if (k >= 6 && k < 11) begin
        n_vec++;
        assert (in_ready === 1'b0 && out_valid === 1'b1 && product === held)
          else begin n_err++; $error("FAIL stall_k%0d: got rdy=%b ov=%b p=%h want 0/1/%h",
                                     k, in_ready, out_valid, product, held); end
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_vec++;
    assert (idx == 30 && n_push == n_pop && q.size() == 0)
      else begin n_err++; $error("FAIL drain: got sent=%0d push=%0d pop=%0d left=%0d want 30/equal/0",
                                 idx, n_push, n_pop, q.size()); end
    @(posedge clk); #1;

    // Step 5a: MAC sequence 3*4 (clear), 255*15, 1*1.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; signed_en = 1'b0; acc_en = 1'b1; acc_clr = (k == 0);
      a = (k == 0) ? 16'd3 : ((k == 1) ? 16'd255 : 16'd1);
      b = (k == 0) ? 16'd4 : ((k == 1) ? 16'd15  : 16'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_vec++;
    assert (acc === 40'd3838 && acc_ovf === 1'b0)
      else begin n_err++; $error("FAIL mac_sum: got %0d/%b want 3838/0", acc, acc_ovf); end
    @(posedge clk); #1;

    // Step 5b: 33-bit accumulator overflows on the third 0xFFFF^2 and a clearing beat resets the flag.
    acc2_m = 0; ovf2_m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid2 = 1'b1; a2 = 16'hFFFF; b2 = 16'hFFFF; acc_clr2 = 1'b0;
      acc_step(AW2, ref_mul(16'hFFFF, 16'hFFFF, 1'b0), 1'b0, 1'b0, acc2_m, ovf2_m);
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_vec++;
    assert (acc2 === acc2_m[AW2-1:0] && acc_ovf2 === ovf2_m && acc_ovf2 === 1'b1)
      else begin n_err++; $error("FAIL acc33_ovf: got %h/%b want %h/%b", acc2, acc_ovf2, acc2_m[AW2-1:0], ovf2_m); end
    @(posedge clk); #1;
    in_valid2 = 1'b1; acc_clr2 = 1'b1;
    acc_step(AW2, ref_mul(16'hFFFF, 16'hFFFF, 1'b0), 1'b0, 1'b1, acc2_m, ovf2_m);
    @(posedge clk); #1;
    in_valid2 = 1'b0; acc_clr2 = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_vec++;
    assert (acc2 === 33'h0FFFE0001 && acc_ovf2 === 1'b0 && acc2 === acc2_m[AW2-1:0])
      else begin n_err++; $error("FAIL acc33_clr: got %h/%b want %h/0", acc2, acc_ovf2, acc2_m[AW2-1:0]); end
    @(posedge clk); #1;

    // Step 6: reset with three beats in flight discards them and clears the accumulator.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = 16'(k + 5); b = 16'd7; signed_en = 1'b0; acc_en = 1'b1; acc_clr = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; acc_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    n_vec++;
    assert (cnt == 0 && acc === '0 && acc_ovf === 1'b0 && in_ready === 1'b1)
      else begin n_err++; $error("FAIL mid_reset: got outs=%0d acc=%h ovf=%b rdy=%b want 0/0/0/1",
                                 cnt, acc, acc_ovf, in_ready); end
    @(posedge clk); #1;
    run_one(16'h1234, 16'h5678, 1'b0, 32'h06260060, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
